// File: rtl/seq_muldiv.sv
// seq_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit producing HI/LO.
// Shift-add multiply and restoring divide, both built on one shared N-bit adder.
// Optional build macro MULDIV_EARLY_TERM_EN: a multiply leaves CALC as soon as
// the remaining multiplier bits are all zero. Without it every op takes N+2 cycles.
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold the last result
// CALC  | one multiply or divide iteration per cycle
// FIX   | sign correction and special cases; hi/lo written
// DONE  | done pulse; a new start is accepted here too
module seq_muldiv #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            is_div;
    logic            neg_q;     // product or quotient must be negated
    logic            neg_r;     // remainder must be negated (dividend was negative)
    logic            dz;        // divisor was zero
    logic [N-1:0]    acc_hi;    // multiply: running high half; divide: remainder
    logic [N-1:0]    acc_lo;    // multiply: low half + multiplier; divide: quotient
    logic [N-1:0]    opa;       // multiply: |multiplicand|; divide: raw dividend
    logic [N-1:0]    opb;       // |divisor|, or remaining multiplier bits

    logic            a_neg, b_neg;
    logic [N-1:0]    a_mag, b_mag;
    logic [N-1:0]    rem_s;
    logic [N-1:0]    add_a, add_b, add_sum;
    logic            add_ci, add_co;
    logic            no_borrow;
    logic [N-1:0]    nxt_hi, nxt_lo;
    logic [2*N-1:0]  prod, prod_neg;

    // Operand magnitudes for signed ops
    always_comb begin
        a_neg = !op[0] && a[N-1];
        b_neg = !op[0] && b[N-1];
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // Shared adder and the next-iteration accumulator for both algorithms
    always_comb begin
        rem_s  = {acc_hi[N-2:0], acc_lo[N-1]};
        add_a  = is_div ? rem_s : acc_hi;
        add_b  = is_div ? ~opb : (acc_lo[0] ? opa : '0);
        add_ci = is_div;
        {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_ci};
        // The bit shifted out of the remainder is the 33rd bit of the N+1-bit compare
        no_borrow = acc_hi[N-1] | add_co;
        if (is_div) begin
            nxt_hi = no_borrow ? add_sum : rem_s;
            nxt_lo = {acc_lo[N-2:0], no_borrow};
        end else begin
            nxt_hi = {add_co, add_sum[N-1:1]};
            nxt_lo = {add_sum[0], acc_lo[N-1:1]};
        end
        prod     = {acc_hi, acc_lo};
        prod_neg = ~prod + 1'b1;
    end

`ifdef MULDIV_EARLY_TERM_EN
    logic            term;
    logic [CW-1:0]   rem_cnt;
    logic [2*N-1:0]  prod_sh;

    // Early exit once the unprocessed multiplier bits are all zero
    always_comb begin
        term    = !is_div && ((opb >> 1) == '0);
        rem_cnt = CNT_LAST - cnt;
        prod_sh = {nxt_hi, nxt_lo} >> rem_cnt;
    end
`endif

    // Controller, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            acc_hi <= '0;
            acc_lo <= '0;
            opa    <= '0;
            opb    <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= CALC;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        is_div <= op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dz     <= (b == '0);
                        acc_hi <= '0;
                        acc_lo <= op[1] ? a_mag : b_mag;
                        opa    <= op[1] ? a : a_mag;
                        opb    <= b_mag;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
`ifdef MULDIV_EARLY_TERM_EN
                    opb <= is_div ? opb : (opb >> 1);
                    if (term || cnt == CNT_LAST) begin
                        state  <= FIX;
                        {acc_hi, acc_lo} <= is_div ? {nxt_hi, nxt_lo} : prod_sh;
                    end else begin
                        {acc_hi, acc_lo} <= {nxt_hi, nxt_lo};
                    end
`else
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    if (cnt == CNT_LAST) state <= FIX;
`endif
                end
                FIX: begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (!is_div) begin
                        {hi, lo} <= neg_q ? prod_neg : prod;
                    end else if (dz) begin
                        lo <= '1;
                        hi <= opa;
                    end else begin
                        lo <= neg_q ? (~acc_lo + 1'b1) : acc_lo;
                        hi <= neg_r ? (~acc_hi + 1'b1) : acc_hi;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
